// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 block cipher, one round per clock.
// Encrypts or decrypts one block at a time with valid/ready handshakes on
// both sides. The expanded key schedule comes from an external key-expansion
// block and must stay stable from accept until the output handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   key        cipher key, carried for interface compatibility only
//   w          expanded key, round key r = w[r*128 +: 128]
//   in_valid   block presented           in_ready   core idle, can accept
//   in_dec     1 = decrypt, 0 = encrypt  in_data    input block, bit 127 = byte 0
//   out_valid  result held               out_ready  downstream accepts
//   out_data   result block              busy       block in flight or held
//
// state  | meaning
// S_IDLE | waiting for a block, in_ready high
// S_RUN  | one round per cycle, rc_q = round being computed
// S_DONE | result held on out_data until out_ready
module aes_iter_core #(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [nk*32-1:0]      key,
   input  logic [0:(nr+1)*128-1] w,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_dec,
   input  logic [127:0]          in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          out_data,
   output logic                  busy
);

   localparam int RCW = $clog2(nr + 1);
   localparam logic [RCW-1:0] NR_C   = RCW'(nr);
   localparam logic [RCW-1:0] RC_ONE = RCW'(1);

   if ((nr != nk + 6) || !((nk == 4) || (nk == 6) || (nk == 8))) begin : g_param_check
      $error("aes_iter_core: nk must be 4/6/8 and nr must equal nk+6");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_f(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox_f(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   // (Inv)ShiftRows fused with (Inv)SubBytes; byte i sits at row i%4, column i/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   b;
      int           src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
            b   = s[127 - 8*src -: 8];
            o[127 - 8*(4*c + r) -: 8] = inv ? inv_sbox_f(b) : sbox_f(b);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
         for (int r = 0; r < 4; r++) begin
            if (inv) begin
               o[127 - 8*(4*c + r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                         ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
            end else begin
               o[127 - 8*(4*c + r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                         ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
         end
      end
      return o;
   endfunction

   state_t         state_q, state_d;
   logic [RCW-1:0] rc_q, rc_d;
   logic [127:0]   st_q, st_d;
   logic [127:0]   out_q, out_d;
   logic           dec_q, dec_d;

   logic [RCW-1:0] key_idx;
   logic [127:0]   rk;
   logic [127:0]   fwd_sr;
   logic [127:0]   inv_sr;
   logic           key_unused;

   assign key_unused = ^key;

   // In IDLE the key index follows the incoming mode so the whitening XOR
   // happens on the accept edge; in RUN decrypt walks the schedule backwards.
   always_comb begin
      if (state_q == S_IDLE) key_idx = in_dec ? NR_C : '0;
      else                   key_idx = dec_q ? (NR_C - rc_q) : rc_q;
   end

   assign rk     = w[{key_idx, 7'd0} +: 128];
   assign fwd_sr = sub_shift(st_q, 1'b0);
   assign inv_sr = sub_shift(st_q, 1'b1);

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      st_d    = st_q;
      out_d   = out_q;
      dec_d   = dec_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dec_d   = in_dec;
               st_d    = in_data ^ rk;
               rc_d    = RC_ONE;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (rc_q == NR_C) begin
               out_d   = dec_q ? (inv_sr ^ rk) : (fwd_sr ^ rk);
               state_d = S_DONE;
            end else begin
               st_d = dec_q ? mix(inv_sr ^ rk, 1'b1) : (mix(fwd_sr, 1'b0) ^ rk);
               rc_d = rc_q + RC_ONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rc_q    <= '0;
         st_q    <= '0;
         out_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         st_q    <= st_d;
         out_q   <= out_d;
         dec_q   <= dec_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_q;

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES block cipher core for 128/192/256-bit keys, selected by parameter. Performs encryption or decryption, chosen per block. Executes one round per clock using the existing round/last_round datapath plus inv_round/inv_last_round. Replaces the free-running encrypt block with a valid/ready handshake on both sides, output backpressure, and deterministic reset. Sits between the key-expansion block (supplies w) and the block-mode/stream wrapper.

Parameters:
nk, 4, key length in 32-bit words; legal values 4/6/8.
nr, 10, round count; must equal nk+6 (elaboration-time check, $error otherwise).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
key  input  nk*32  cipher key; informational only, no datapath use, kept for interface compatibility
w  input  (nr+1)*128  expanded key, declared [0:(nr+1)*128-1]; round key r = w[r*128 +: 128]; must stay stable from accept until output handshake
in_valid  input  1  block presented
in_ready  output  1  core can accept
in_dec  input  1  0 = encrypt, 1 = decrypt; sampled at accept
in_data  input  128  plaintext/ciphertext; bit 127 = byte 0
out_valid  output  1  result held
out_ready  input  1  downstream accepts
out_data  output  128  result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (sync, active-high, overrides all): state = IDLE; round counter = 0; state register = 0; out_data = 0; out_valid = 0; in_ready = 1; busy = 0. Reset asserted mid-RUN or mid-DONE discards the block. No output is ever X.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- in_ready = (FSM == IDLE), combinational from the state only. out_valid = (FSM == DONE).
- IDLE:
  - Accept on the edge where in_valid && in_ready. Latch dec = in_dec.
  - Encrypt: st <= in_data ^ rk0. Decrypt: st <= in_data ^ rk[nr].
  - Set rc <= 1 and go to RUN.
  - in_valid low: hold all state.
- RUN, encrypt, rc < nr: st <= round(st, rk[rc]); rc <= rc+1.
- RUN, encrypt, rc == nr: out_data <= last_round(st, rk[nr]); go to DONE.
- RUN, decrypt: uses key index nr-rc.
  - rc < nr: st <= inv_round(st, rk[nr-rc]). inv_round = InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - rc == nr: out_data <= inv_last_round(st, rk0). inv_last_round = InvShiftRows, InvSubBytes, AddRoundKey.
- Latency: out_valid rises exactly nr cycles after the accept edge (10/12/14).
- in_valid and inputs are ignored while busy. No second block is queued.
- DONE:
  - out_data and out_valid hold stable while out_ready = 0 (unbounded stall).
  - On the edge with out_ready = 1: go to IDLE, out_valid -> 0. out_data keeps its last value.
- Minimum accept-to-accept spacing: nr+2 cycles. out_ready high in the same cycle out_valid rises completes the handshake on the next edge.
- Width rules: all XOR/round ops are 128-bit. rc width = $clog2(nr+1). No arithmetic overflow is possible.
- w or in_data toggling outside the accept edge while in IDLE has no effect.

Test Plan:
- nk=4, encrypt, in_data 00112233445566778899aabbccddeeff, key/w from 000102030405060708090a0b0c0d0e0f -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- nk=4, decrypt 3925841d02dc09fbdc118597196a0b32 with key 2b7e151628aed2a6abf7158809cf4f3c -> 3243f6a8885a308d313198a2e0370734. Then encrypt back-to-back on the same instance -> original ciphertext.
- nk=6, key 000102…1617, encrypt 00112233…eeff -> dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles. nk=8, key 00…1f -> 8ea2b7ca516745bfeafc49904b496089 at 14 cycles. Decrypt of each returns the plaintext.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_data stable, in_ready = 0, new in_valid ignored. Release -> IDLE next edge, then accept a new block.
- Reset at RUN round 5 -> next edge all outputs at reset values, in_ready = 1. A fresh block then completes with the correct FIPS-197 result.
- Random: 500 blocks, random mode/keys/gaps/out_ready stalls, compared against a reference model. Check that no output is X after reset.
